// File: rtl/apb_master_bridge.sv
// CPU data-bus to APB bridge: window decode plus IDLE/SETUP/ACCESS sequencing.
// Define APB_TIMEOUT_EN to bound ACCESS waits by TIMEOUT_CYCLES.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter logic [31:0] SLAVE_SPAN     = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);

    localparam int unsigned SHIFT = $clog2(SLAVE_SPAN);
    localparam int unsigned IW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;
    logic          mapped_q, mapped_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [31:0] off;
    logic [31:0] win;
    logic        hit;
    logic        in_access;
    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;
    logic        timeout;
    logic        done;

    assign off = addr - BASE_ADDR;
    assign win = off >> SHIFT;
    assign hit = (addr >= BASE_ADDR) && (win < NUM_SLAVES);

    assign in_access = (state_q == S_ACCESS);
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[idx_q*32 +: 32];

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts stalled ACCESS cycles already seen, so the
    // TIMEOUT_CYCLES-th stalled cycle is the one that completes
    assign timeout = in_access && mapped_q && !sel_ready &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_SETUP) begin
            cnt_d = '0;
        end else if (in_access && mapped_q && !sel_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign done = in_access && (!mapped_q || sel_ready || timeout);

    // Completion is suppressed while reset is asserted so an aborted
    // transfer never reports ready
    assign ready = done && !reset;
    assign err   = ready && (!mapped_q || (sel_ready ? sel_err : 1'b1));
    assign rdata = (ready && mapped_q && sel_ready && !pwrite_q) ?
                   sel_rdata : 32'h0;

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = in_access && mapped_q;
    assign PSEL    = (mapped_q && (state_q != S_IDLE)) ?
                     (NUM_SLAVES'(1) << idx_q) : '0;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        mapped_d = mapped_q;
        idx_d    = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = write;
                    mapped_d = hit;
                    idx_d    = hit ? IW'(win) : '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            mapped_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            mapped_q <= mapped_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, corner sequences
// and randomized transfers against an address-window reference model.
module tb_apb_master_bridge;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SPAN = 32'h0000_1000;
    localparam int          TO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          transfer;
    logic          write;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic          PENABLE;
    logic [NS-1:0] PSEL;
    logic [32*NS-1:0] PRDATA;
    logic [NS-1:0] PREADY;
    logic [NS-1:0] PSLVERR;

    int checks   = 0;
    int failures = 0;

    apb_master_bridge #(
        .NUM_SLAVES(NS),
        .BASE_ADDR(BASE),
        .SLAVE_SPAN(SPAN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .transfer(transfer),
        .write(write),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .err(err),
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PENABLE(PENABLE),
        .PSEL(PSEL),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        bit          slverr;
        logic [31:0] rd;
        logic [NS-1:0] psel;
        int          k;
        bit          e;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address-window reference: plain arithmetic on the memory map
    function automatic void model(input logic [31:0] a, output bit m,
                                  output int sel);
        longint unsigned o;
        m   = 1'b0;
        sel = 0;
        if (a >= BASE) begin
            o = longint'(a - BASE);
            if (o / longint'(SPAN) < NS) begin
                m   = 1'b1;
                sel = int'(o / longint'(SPAN));
            end
        end
    endfunction

    task automatic run_xfer(input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int waits,
                            input bit slverr, input logic [31:0] rd,
                            input logic [NS-1:0] exp_psel, input int exp_k,
                            input bit exp_err, input logic [31:0] exp_rdata,
                            input string tag);
        bit m;
        int sel;
        model(a, m, sel);
        @(posedge clk);
        #1;
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = wd;
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
        PREADY  = NS'($urandom);
        PSLVERR = NS'($urandom);
        if (m) begin
            PRDATA[32*sel +: 32] = rd;
            PSLVERR[sel]         = slverr;
            PREADY[sel]          = 1'b0;
        end
        @(posedge clk);
        #1;
        transfer = 1'($urandom);
        write    = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        @(negedge clk);
        chk({tag, ".setup_psel"}, 32'(PSEL), 32'(exp_psel));
        chk({tag, ".setup_penable"}, 32'(PENABLE), 32'(0));
        chk({tag, ".setup_ready"}, 32'(ready), 32'(0));
        chk({tag, ".setup_paddr"}, PADDR, a);
        for (int k = 0; k <= exp_k; k++) begin
            @(posedge clk);
            #1;
            if (m) PREADY[sel] = (k >= waits);
            @(negedge clk);
            chk({tag, ".psel"}, 32'(PSEL), 32'(exp_psel));
            chk({tag, ".penable"}, 32'(PENABLE), 32'(m));
            chk({tag, ".paddr"}, PADDR, a);
            chk({tag, ".pwdata"}, PWDATA, wd);
            chk({tag, ".pwrite"}, 32'(PWRITE), 32'(wr));
            if (k < exp_k) begin
                chk({tag, ".wait_ready"}, 32'(ready), 32'(0));
                if (ready) break;
            end else begin
                chk({tag, ".ready"}, 32'(ready), 32'(1));
                chk({tag, ".err"}, 32'(err), 32'(exp_err));
                chk({tag, ".rdata"}, rdata, exp_rdata);
            end
        end
        transfer = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'h1000_1004, 32'h0, 0, 1'b0, 32'hCAFE_0001,
                   4'b0010, 0, 1'b0, 32'hCAFE_0001};
        tbl[1] = '{1'b1, 32'h1000_2000, 32'h55, 3, 1'b0, 32'hDEAD_BEEF,
                   4'b0100, 3, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h1000_4000, 32'h0, 2, 1'b0, 32'h1111_2222,
                   4'b0000, 0, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h1000_0010, 32'h0, 0, 1'b1, 32'h1234_5678,
                   4'b0001, 0, 1'b1, 32'h1234_5678};
        tbl[4] = '{1'b0, 32'h1000_3FFF, 32'h0, 1, 1'b0, 32'hA5A5_0003,
                   4'b1000, 1, 1'b0, 32'hA5A5_0003};
        tbl[5] = '{1'b0, 32'h0FFF_FFFF, 32'h0, 0, 1'b0, 32'h7777_7777,
                   4'b0000, 0, 1'b1, 32'h0};
        tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'h99, 0, 1'b0, 32'h0,
                   4'b0000, 0, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 32'h1000_3000, 32'hABCD, 2, 1'b1, 32'h0,
                   4'b1000, 2, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 32'h1000_0000, 32'h0, 0, 1'b0, 32'h0000_0001,
                   4'b0001, 0, 1'b0, 32'h0000_0001};

        reset    = 1'b1;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        PRDATA   = '1;
        PREADY   = '1;
        PSLVERR  = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.psel", 32'(PSEL), 32'(0));
        chk("rst.penable", 32'(PENABLE), 32'(0));
        chk("rst.paddr", PADDR, 32'h0);
        chk("rst.pwdata", PWDATA, 32'h0);
        chk("rst.pwrite", 32'(PWRITE), 32'(0));
        chk("rst.ready", 32'(ready), 32'(0));
        chk("rst.err", 32'(err), 32'(0));
        chk("rst.rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_xfer(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].waits,
                     tbl[i].slverr, tbl[i].rd, tbl[i].psel, tbl[i].k,
                     tbl[i].e, tbl[i].r, $sformatf("vec%0d", i));
        end

        // Reset while a transfer is stalled in ACCESS
        @(posedge clk);
        #1;
        transfer = 1'b1;
        write    = 1'b0;
        addr     = 32'h1000_1000;
        PREADY   = '0;
        @(posedge clk);
        #1;
        transfer = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid.penable_before", 32'(PENABLE), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.ready_during", 32'(ready), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid.psel", 32'(PSEL), 32'(0));
        chk("rstmid.penable", 32'(PENABLE), 32'(0));
        chk("rstmid.paddr", PADDR, 32'h0);
        PREADY = '1;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid.ready_idle", 32'(ready), 32'(0));
            chk("rstmid.psel_idle", 32'(PSEL), 32'(0));
        end
        run_xfer(1'b0, 32'h1000_1008, 32'h0, 0, 1'b0, 32'hBEEF_0002,
                 4'b0010, 0, 1'b0, 32'hBEEF_0002, "after_rst");

`ifdef APB_TIMEOUT_EN
        run_xfer(1'b0, 32'h1000_3000, 32'h0, 1000, 1'b0, 32'h5555_AAAA,
                 4'b1000, TO - 1, 1'b1, 32'h0, "timeout");
        run_xfer(1'b0, 32'h1000_0004, 32'h0, 0, 1'b0, 32'h0BAC_0B0B,
                 4'b0001, 0, 1'b0, 32'h0BAC_0B0B, "b2b");
        run_xfer(1'b0, 32'h1000_2004, 32'h0, TO - 1, 1'b0, 32'h600D_F00D,
                 4'b0100, TO - 1, 1'b0, 32'h600D_F00D, "pready_wins");
`endif

        for (int n = 0; n < 60; n++) begin
            bit          wr, sv, m;
            int          sel, w;
            logic [31:0] a, wd, rd;
            logic [NS-1:0] ep;
            wr = 1'($urandom);
            sv = 1'($urandom);
            w  = $urandom_range(0, 4);
            wd = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE - 32'd16 + $urandom_range(0, 4 * 32'h1000 + 64);
            model(a, m, sel);
            ep = m ? NS'(1 << sel) : '0;
            run_xfer(wr, a, wd, w, sv, rd, ep, m ? w : 0, !m || sv,
                     (m && !wr) ? rd : 32'h0, $sformatf("rnd%0d", n));
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
